// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg : shared types and helpers for the load/store unit            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  // Unshifted byte-lane mask for an access of the given size.
  function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// +----------------------------------------------------------------------+
// | lsu_lane_align : store lane shift/strobes, load extract and extension |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]                   i_size,
  input  logic [$clog2(XLEN/8)-1:0]    i_off,
  input  logic                         i_unsigned,
  input  logic [XLEN-1:0]              i_store_value,
  input  logic [XLEN-1:0]              i_mem_rdata,
  output logic [XLEN/8-1:0]            o_wstrb,
  output logic [XLEN-1:0]              o_wdata,
  output logic [XLEN-1:0]              o_load_value
);

  localparam int c_BYTES = XLEN / 8;
  localparam int c_SW    = $clog2(XLEN);

  logic [c_BYTES-1:0] w_mask;
  logic [XLEN-1:0]    w_bitmask;
  logic [XLEN-1:0]    w_shifted;
  logic [c_SW-1:0]    w_shamt;
  logic [c_SW-1:0]    w_sign_idx;
  logic               w_sign;

  always_comb begin
    w_mask    = c_BYTES'(size_byte_mask(i_size));
    w_bitmask = '0;
    for (int i = 0; i < c_BYTES; i++) begin
      w_bitmask[8*i +: 8] = {8{w_mask[i]}};
    end
    w_shamt = {i_off, 3'b000};
    case (i_size)
      2'd0:    w_sign_idx = c_SW'(7);
      2'd1:    w_sign_idx = c_SW'(15);
      2'd2:    w_sign_idx = c_SW'(31);
      default: w_sign_idx = c_SW'(XLEN - 1);
    endcase
    w_shifted    = i_mem_rdata >> w_shamt;
    w_sign       = ~i_unsigned & w_shifted[w_sign_idx];
    o_wstrb      = w_mask << i_off;
    o_wdata      = i_store_value << w_shamt;
    // Bits above the access width are filled with the sign (or zero).
    o_load_value = (w_shifted & w_bitmask) | ({XLEN{w_sign}} & ~w_bitmask);
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------+
// | load_store_unit : EA calc, sized memory access, wait/timeout, response|
// | Optional macro LSU_MISALIGN_TRAP_EN traps misaligned requests.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [XLEN-1:0]     read1,
  input  logic [XLEN-1:0]     immediate,
  input  logic [XLEN-1:0]     store_value,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [XLEN-1:0]     load_value,
  output logic [XLEN-1:0]     dataAddr_reg,
  output logic                mem_re,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_ready
);

  localparam int c_OW      = $clog2(XLEN / 8);
  localparam int c_CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int c_TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [c_CNT_W-1:0] c_TO_LAST_CNT = c_CNT_W'(c_TO_LAST);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_DONE   = ST_DONE;

  logic [1:0]         r_state;
  logic               r_we;
  lsu_size_e          r_size;
  logic               r_unsigned;
  logic [c_OW-1:0]    r_off;
  logic [XLEN-1:0]    r_store;
  logic [XLEN-1:0]    r_addr;
  logic [c_CNT_W-1:0] r_wait;
  logic               r_err;
  logic [XLEN-1:0]    r_load;

  logic [XLEN-1:0]    w_ea;
  logic [c_OW-1:0]    w_off;
  logic [c_OW-1:0]    w_lowmask;
  logic [c_OW-1:0]    w_off_use;
  logic               w_illegal;
  logic               w_err;
  logic               w_timeout;
  logic               w_access;
  logic [XLEN/8-1:0]  w_strb;
  logic [XLEN-1:0]    w_wdata;
  logic [XLEN-1:0]    w_load;

  assign w_ea      = read1 + immediate;
  assign w_off     = w_ea[c_OW-1:0];
  assign w_lowmask = c_OW'(size_byte_mask(req_size) >> 1);
  assign w_illegal = (XLEN == 32) && (req_size == SZ_D);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal   = |(w_off & w_lowmask);
  assign w_err     = w_illegal | w_misal;
  assign w_off_use = w_off;
`else
  // Misaligned requests are silently aligned down to the access size.
  assign w_err     = w_illegal;
  assign w_off_use = w_off & ~w_lowmask;
`endif

  assign w_timeout = (TIMEOUT_CYC != 0) && (r_wait == c_TO_LAST_CNT);
  assign w_access  = (r_state == S_ACCESS);

  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_lane_align (
    .i_size        (r_size),
    .i_off         (r_off),
    .i_unsigned    (r_unsigned),
    .i_store_value (r_store),
    .i_mem_rdata   (mem_rdata),
    .o_wstrb       (w_strb),
    .o_wdata       (w_wdata),
    .o_load_value  (w_load)
  );

  assign req_ready    = (r_state == S_IDLE);
  assign resp_valid   = (r_state == S_DONE);
  assign resp_err     = r_err;
  assign load_value   = r_load;
  assign dataAddr_reg = r_addr;
  assign mem_re       = w_access & ~r_we;
  assign mem_we       = w_access & r_we;
  assign mem_wstrb    = w_access ? w_strb : '0;
  assign mem_wdata    = (w_access && r_we) ? w_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_off      <= '0;
      r_store    <= '0;
      r_addr     <= '0;
      r_wait     <= '0;
      r_err      <= 1'b0;
      r_load     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= lsu_size_e'(req_size);
            r_unsigned <= req_unsigned;
            r_off      <= w_off_use;
            r_store    <= store_value;
            r_addr     <= {w_ea[XLEN-1:c_OW], {c_OW{1'b0}}};
            r_wait     <= '0;
            r_err      <= w_err;
            r_load     <= '0;
            r_state    <= w_err ? S_DONE : S_ACCESS;
          end
        end
        S_ACCESS: begin
          // A ready in the final wait cycle beats the timeout.
          if (mem_ready) begin
            if (!r_we) begin
              r_load <= w_load;
            end
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wait <= r_wait + c_CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------+
// | tb_load_store_unit : directed scoreboard bench for load_store_unit    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [XLEN-1:0]   read1 = '0;
  logic [XLEN-1:0]   immediate = '0;
  logic [XLEN-1:0]   store_value = '0;
  logic              resp_valid;
  logic              resp_err;
  logic [XLEN-1:0]   load_value;
  logic [XLEN-1:0]   dataAddr_reg;
  logic              mem_re;
  logic              mem_we;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata = '0;
  logic              mem_ready = 1'b0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [32:0] sb[$];
  logic [31:0] last_ld = '0;
  logic        last_err = 1'b0;

  load_store_unit #(
    .XLEN        (XLEN),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .read1        (read1),
    .immediate    (immediate),
    .store_value  (store_value),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .load_value   (load_value),
    .dataAddr_reg (dataAddr_reg),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected resp_valid", 32'(resp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_err", 32'(resp_err), 32'(e[32]));
        chk("load_value", load_value, e[31:0]);
      end
    end
  end

  task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] r1, input logic [31:0] imm, input logic [31:0] sv,
                     input logic [31:0] rdata, input int waits, input logic acc,
                     input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic err, input logic [31:0] ld);
    int i;
    bit fin;
    @(negedge clk);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, " held load_value"}, load_value, last_ld);
    chk({tag, " held resp_err"}, 32'(resp_err), 32'(last_err));
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    read1 = r1; immediate = imm; store_value = sv;
    sb.push_back({err, ld});
    last_ld = ld; last_err = err;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; read1 = $urandom; immediate = $urandom;
    store_value = $urandom; req_size = 2'($urandom_range(0, 3));
    if (!acc) begin
      chk({tag, " err-path resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " no strobe"}, 32'({mem_re, mem_we, mem_wstrb}), 32'd0);
    end else begin
      i = 0;
      fin = 1'b0;
      while (!fin) begin
        chk({tag, " mem_re"}, 32'(mem_re), 32'(!we));
        chk({tag, " mem_we"}, 32'(mem_we), 32'(we));
        chk({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'(strb));
        chk({tag, " dataAddr_reg"}, dataAddr_reg, addr);
        if (we) chk({tag, " mem_wdata"}, mem_wdata, wdata);
        chk({tag, " early resp_valid"}, 32'(resp_valid), 32'd0);
        if (i == waits) begin
          mem_ready = 1'b1; mem_rdata = rdata; fin = 1'b1;
        end else begin
          mem_ready = 1'b0; mem_rdata = $urandom;
          if (i == TO - 1) fin = 1'b1;
        end
        @(negedge clk);
        mem_ready = 1'b0;
        i++;
      end
      chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " strobes down"}, 32'({mem_re, mem_we, mem_wstrb}), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp", 32'({resp_valid, resp_err, mem_re, mem_we}), 32'd0);
    chk("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset dataAddr_reg", dataAddr_reg, 32'd0);
    chk("reset load_value", load_value, 32'd0);
    rst_n = 1'b1;

    run("lw",   1'b0, 2'd2, 1'b0, 32'h5C, 32'd4, 32'h0, 32'h00000003, 0, 1'b1, 4'hF, 32'h60, 32'h0, 1'b0, 32'h3);
    run("lb",   1'b0, 2'd0, 1'b0, 32'h60, 32'd1, 32'h0, 32'h0000F000, 0, 1'b1, 4'h2, 32'h60, 32'h0, 1'b0, 32'hFFFFFFF0);
    run("lbu",  1'b0, 2'd0, 1'b1, 32'h60, 32'd1, 32'h0, 32'h0000F000, 0, 1'b1, 4'h2, 32'h60, 32'h0, 1'b0, 32'h000000F0);
    run("sh",   1'b1, 2'd1, 1'b0, 32'h70, 32'hFFFFFFF2, 32'h0000BEEF, 32'h0, 0, 1'b1, 4'hC, 32'h60, 32'hBEEF0000, 1'b0, 32'h0);
    run("sb",   1'b1, 2'd0, 1'b0, 32'h80, 32'd3, 32'h123456A5, 32'h0, 0, 1'b1, 4'h8, 32'h80, 32'hA5000000, 1'b0, 32'h0);
    run("sw w1", 1'b1, 2'd2, 1'b0, 32'h90, 32'd0, 32'hCAFEF00D, 32'h0, 1, 1'b1, 4'hF, 32'h90, 32'hCAFEF00D, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    run("lw mis", 1'b0, 2'd2, 1'b0, 32'h60, 32'd1, 32'h0, 32'h12345678, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0);
    run("lh mis", 1'b0, 1'd1, 1'b0, 32'h60, 32'd3, 32'h0, 32'h80010000, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0);
`else
    run("lw mis", 1'b0, 2'd2, 1'b0, 32'h60, 32'd1, 32'h0, 32'h12345678, 0, 1'b1, 4'hF, 32'h60, 32'h0, 1'b0, 32'h12345678);
    run("lh mis", 1'b0, 2'd1, 1'b0, 32'h60, 32'd3, 32'h0, 32'h80010000, 0, 1'b1, 4'hC, 32'h60, 32'h0, 1'b0, 32'hFFFF8001);
`endif
    run("illegal", 1'b0, 2'd3, 1'b0, 32'h60, 32'd0, 32'h0, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0);
    run("timeout", 1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 32'h0, 32'h55555555, -1, 1'b1, 4'hF, 32'h80, 32'h0, 1'b1, 32'h0);
    run("rdy last", 1'b0, 2'd1, 1'b0, 32'h80, 32'd6, 32'h0, 32'h80010000, TO - 1, 1'b1, 4'hC, 32'h84, 32'h0, 1'b0, 32'hFFFF8001);

    // mem_ready while idle must not produce a response
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle ready resp_valid", 32'(resp_valid), 32'd0);
      chk("idle ready req_ready", 32'(req_ready), 32'd1);
    end
    mem_ready = 1'b0;

    // reset in the middle of an access
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; read1 = 32'h40; immediate = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst pre mem_re", 32'(mem_re), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst strobes", 32'({mem_re, mem_we, mem_wstrb}), 32'd0);
    chk("rst addr", dataAddr_reg, 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post rst resp_valid", 32'(resp_valid), 32'd0);
      chk("post rst req_ready", 32'(req_ready), 32'd1);
    end
    last_ld = '0; last_err = 1'b0;

    run("lw post", 1'b0, 2'd2, 1'b0, 32'h5C, 32'd4, 32'h0, 32'h00000007, 0, 1'b1, 4'hF, 32'h60, 32'h0, 1'b0, 32'h7);

    @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
